// File: rtl/nn_layer_pkg.sv
// -----------------------------------------------------------------------------
// nn_layer_pkg
//
// Purpose:
//   Shared definitions for the neural-network layer weight path. Holds the
//   layer-1 dimension constants, the weight memory geometry, and the
//   writer/loader state encoding.
//
// Contents:
//   L1_IN_SIZE      number of layer-1 inputs
//   L1_OUT_SIZE     number of layer-1 outputs (neurons)
//   WEIGHT_W        bits per weight
//   WEIGHT_ADDR_W   weight memory address width
//   L1_WEIGHT_BASE  memory address of layer-1 weight index 0
//   wr_state_e      IDLE / WRITE / FINISH transfer states
//   index_width()   width of a word index that can also hold the word count
// -----------------------------------------------------------------------------
package nn_layer_pkg;

    localparam int L1_IN_SIZE     = 3;
    localparam int L1_OUT_SIZE    = 2;
    localparam int WEIGHT_W       = 8;
    localparam int WEIGHT_ADDR_W  = 18;
    localparam int L1_WEIGHT_BASE = 0;

    // Transfer states shared by the weight writer and the weight loader.
    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_WRITE  = 2'd1,
        WR_FINISH = 2'd2
    } wr_state_e;

    // One extra bit over clog2 so the index can reach the word count itself
    // without wrapping; this also gives a 1-bit index for a single word.
    function automatic int index_width(input int n_words);
        return $clog2(n_words) + 1;
    endfunction

endpackage : nn_layer_pkg

// File: rtl/weight_word_select.sv
// -----------------------------------------------------------------------------
// weight_word_select
//
// Purpose:
//   Combinational word selector for a flattened weight bus. Returns the W-bit
//   word at data_i[index_i*W +: W]. An index at or beyond N_WORDS returns zero,
//   so a look-ahead index one past the last word is harmless.
//
// Ports:
//   data_i   in   N_WORDS*W  flattened weights, word k at bits [k*W +: W]
//   index_i  in   IDX_W      word index
//   word_o   out  W          selected word
// -----------------------------------------------------------------------------
module weight_word_select
    import nn_layer_pkg::*;
#(
    parameter int W       = WEIGHT_W,
    parameter int N_WORDS = L1_IN_SIZE * L1_OUT_SIZE,
    parameter int IDX_W   = index_width(N_WORDS)
) (
    input  logic [N_WORDS*W-1:0] data_i,
    input  logic [IDX_W-1:0]     index_i,
    output logic [W-1:0]         word_o
);

    // A mux written as a compare-per-word loop keeps the part-select bases
    // constant, which synthesises to a clean one-hot mux.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an index that matches no word would infer a latch.
        word_o = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            if (index_i == IDX_W'(k)) begin
                word_o = data_i[k*W +: W];
            end
        end
    end

endmodule : weight_word_select

// File: rtl/weight_writer_layer1.sv
// -----------------------------------------------------------------------------
// weight_writer_layer1
//
// Purpose:
//   Write-side counterpart of the layer-1 weight loader. On a start request it
//   snapshots a flattened weight vector and writes it word-by-word into the
//   weight BRAM, using the same row-major packing (k = o*IN_SIZE + i) and the
//   same address layout (BASE_ADDR + k) the loader reads back.
//
// Ports:
//   clk        in   1                 system clock, rising edge
//   rst_n      in   1                 asynchronous active-low reset
//   start      in   1                 level request to store data_in
//   data_in    in   TOTAL_WEIGHTS*W   flattened weights, weight k at [k*W +: W]
//   mem_ready  in   1                 memory accepts a write this cycle
//   mem_we     out  1                 write enable
//   mem_addr   out  ADDR_WIDTH        write address
//   mem_din    out  W                 write data
//   busy       out  1                 transfer in progress
//   done       out  1                 sticky completion flag
//
// Handshake:
//   A word is written on a rising edge where mem_we=1 and mem_ready=1. While
//   mem_ready is low, mem_we/mem_addr/mem_din hold. With mem_ready tied high
//   and launch edge L, words are written at edges L+1..L+TOTAL_WEIGHTS and
//   done reads 1 after edge L+TOTAL_WEIGHTS+1.
// -----------------------------------------------------------------------------
module weight_writer_layer1
    import nn_layer_pkg::*;
#(
    parameter int                    IN_SIZE    = L1_IN_SIZE,
    parameter int                    OUT_SIZE   = L1_OUT_SIZE,
    parameter int                    W          = WEIGHT_W,
    parameter int                    ADDR_WIDTH = WEIGHT_ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(L1_WEIGHT_BASE)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [IN_SIZE*OUT_SIZE*W-1:0]   data_in,
    input  logic                            mem_ready,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [W-1:0]                    mem_din,
    output logic                            busy,
    output logic                            done
);

    // Derived from the layer shape; not a parameter so it cannot disagree
    // with the width of data_in.
    localparam int                TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE;
    localparam int                IDX_W         = index_width(TOTAL_WEIGHTS);
    localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(TOTAL_WEIGHTS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    wr_state_e                      state_q;
    logic [IDX_W-1:0]               index_q;
    logic                           armed_q;
    logic [TOTAL_WEIGHTS*W-1:0]     snapshot_q;
    logic                           mem_we_q;
    logic [ADDR_WIDTH-1:0]          mem_addr_q;
    logic [W-1:0]                   mem_din_q;
    logic                           busy_q;
    logic                           done_q;

    // Look-ahead values for the word presented after the current one is
    // accepted. Outputs are registered, so the next word is prepared here and
    // loaded on the accepting edge.
    logic [IDX_W-1:0]               index_d;
    logic [ADDR_WIDTH-1:0]          addr_d;
    logic [W-1:0]                   word_d;

    assign index_d = index_q + IDX_W'(1);

    // Address arithmetic is done at ADDR_WIDTH, so BASE_ADDR near the top of
    // the memory wraps through zero.
    assign addr_d  = BASE_ADDR + ADDR_WIDTH'(index_d);

    weight_word_select #(
        .W       (W),
        .N_WORDS (TOTAL_WEIGHTS),
        .IDX_W   (IDX_W)
    ) u_word_select (
        .data_i  (snapshot_q),
        .index_i (index_d),
        .word_o  (word_d)
    );

    // -------------------------------------------------------------------------
    // Transfer FSM with registered outputs
    // -------------------------------------------------------------------------
    // armed_q implements the level-to-pulse behaviour of start: it clears on a
    // launch and is only set again when start is seen low in IDLE, so a start
    // held high, or toggled while busy, never causes a second transfer.
    //
    // The snapshot register is reset along with the control state; it is only
    // 48 bits wide here and a cleared value keeps mem_din deterministic.
    // NOTE: sequential state is assigned with non-blocking (<=) only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WR_IDLE;
            index_q    <= '0;
            armed_q    <= 1'b1;
            snapshot_q <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                WR_IDLE: begin
                    if (start && armed_q) begin
                        // Launch: freeze the weights and present word 0 on
                        // the next cycle straight from data_in, since the
                        // snapshot is being loaded on this same edge.
                        snapshot_q <= data_in;
                        index_q    <= '0;
                        armed_q    <= 1'b0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= BASE_ADDR;
                        mem_din_q  <= data_in[W-1:0];
                        state_q    <= WR_WRITE;
                    end else if (!start) begin
                        armed_q    <= 1'b1;
                    end
                end

                WR_WRITE: begin
                    // mem_we_q is high for the whole of WRITE, so mem_ready
                    // alone decides acceptance; without it everything holds.
                    if (mem_ready) begin
                        index_q <= index_d;
                        if (index_q == LAST_IDX) begin
                            // Last word accepted: the FINISH cycle already
                            // shows mem_we=0 and busy=0.
                            mem_we_q <= 1'b0;
                            busy_q   <= 1'b0;
                            state_q  <= WR_FINISH;
                        end else begin
                            mem_addr_q <= addr_d;
                            mem_din_q  <= word_d;
                        end
                    end
                end

                WR_FINISH: begin
                    // done is sticky until the next launch clears it.
                    done_q  <= 1'b1;
                    state_q <= WR_IDLE;
                end

                default: begin
                    state_q <= WR_IDLE;
                end
            endcase
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule : weight_writer_layer1

// File: tb/tb_weight_writer_layer1.sv
// -----------------------------------------------------------------------------
// tb_weight_writer_layer1
//
// Directed bench for weight_writer_layer1. Two instances share all inputs:
// u_dut uses BASE_ADDR=0, u_dut_wrap uses BASE_ADDR=18'h3FFFE to cover the
// address wrap. Inputs change 1 ns after a rising edge; outputs are sampled on
// the falling edge or 1 ns after a rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_weight_writer_layer1;

    localparam int N_WORDS = 6;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [47:0] data_in;
    logic        mem_ready;

    logic        mem_we;
    logic [17:0] mem_addr;
    logic [7:0]  mem_din;
    logic        busy;
    logic        done;

    logic        wrap_we;
    logic [17:0] wrap_addr;
    logic [7:0]  wrap_din;
    logic        wrap_busy;
    logic        wrap_done;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Writes seen by the memory side of u_dut, in acceptance order.
    logic [17:0] log_addr[$];
    logic [7:0]  log_din[$];

    logic        pend_acc  = 1'b0;
    logic [17:0] pend_addr = '0;
    logic [7:0]  pend_din  = '0;

    weight_writer_layer1 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .busy      (busy),
        .done      (done)
    );

    weight_writer_layer1 #(
        .BASE_ADDR (18'h3FFFE)
    ) u_dut_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .mem_ready (mem_ready),
        .mem_we    (wrap_we),
        .mem_addr  (wrap_addr),
        .mem_din   (wrap_din),
        .busy      (wrap_busy),
        .done      (wrap_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side monitor: the write request is sampled on the falling edge
    // and committed on the following rising edge unless reset intervened.
    always @(negedge clk) begin
        pend_acc  = mem_we && mem_ready;
        pend_addr = mem_addr;
        pend_din  = mem_din;
    end

    always @(posedge clk) begin
        if (pend_acc && rst_n) begin
            log_addr.push_back(pend_addr);
            log_din.push_back(pend_din);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to the drive point just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_din.delete();
    endtask

    // Raise start for one edge with the given weights; returns 1 ns after the
    // launch edge with start low again.
    task automatic launch(input logic [47:0] d);
        clear_log();
        start   = 1'b1;
        data_in = d;
        tick();
        start   = 1'b0;
    endtask

    // Bounded wait for done; an expired bound is a failed comparison.
    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            tick();
            n++;
        end
        check({tag, "_done"}, done, 1'b1);
    endtask

    // Compare the logged writes against six words d[k] at addresses base+k.
    task automatic check_log(input string tag, input logic [17:0] base, input logic [47:0] d);
        logic [17:0] a;
        check({tag, "_count"}, log_addr.size(), N_WORDS);
        for (int k = 0; k < N_WORDS && k < log_addr.size(); k++) begin
            a = base + 18'(k);
            check($sformatf("%s_addr%0d", tag, k), log_addr[k], a);
            check($sformatf("%s_din%0d", tag, k), log_din[k], d[k*8 +: 8]);
        end
    endtask

    localparam logic [47:0] DATA_A = 48'h06_05_04_03_02_01;
    localparam logic [47:0] DATA_B = 48'hAA_AA_AA_AA_AA_AA;

    logic [17:0] wrap_tab[N_WORDS];
    logic [7:0]  byte_tab[N_WORDS];
    int          w;
    logic        rdy;

    initial begin
        wrap_tab = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001, 18'h00002, 18'h00003};
        byte_tab = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

        rst_n     = 1'b0;
        start     = 1'b0;
        data_in   = '0;
        mem_ready = 1'b1;

        // ---------------- reset state ----------------
        #2;
        check("rst_we",        mem_we,    1'b0);
        check("rst_addr",      mem_addr,  18'h0);
        check("rst_din",       mem_din,   8'h0);
        check("rst_busy",      busy,      1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_wrap_addr", wrap_addr, 18'h0);
        #20;
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_we", mem_we, 1'b0);

        // ---------------- basic store, ready high ----------------
        launch(DATA_A);
        for (int k = 0; k < N_WORDS; k++) begin
            @(negedge clk);
            check($sformatf("b_we%0d", k),        mem_we,    1'b1);
            check($sformatf("b_addr%0d", k),      mem_addr,  18'(k));
            check($sformatf("b_din%0d", k),       mem_din,   byte_tab[k]);
            check($sformatf("b_busy%0d", k),      busy,      1'b1);
            check($sformatf("b_done%0d", k),      done,      1'b0);
            check($sformatf("wrap_addr%0d", k),   wrap_addr, wrap_tab[k]);
            check($sformatf("wrap_din%0d", k),    wrap_din,  byte_tab[k]);
            tick();
        end
        @(negedge clk);   // FINISH cycle, after edge L+6
        check("b_fin_we",   mem_we, 1'b0);
        check("b_fin_busy", busy,   1'b0);
        check("b_fin_done", done,   1'b0);
        @(negedge clk);   // after edge L+7
        check("b_done",      done,      1'b1);
        check("b_idle_busy", busy,      1'b0);
        check("wrap_done",   wrap_done, 1'b1);
        check("wrap_busy",   wrap_busy, 1'b0);
        check_log("b", 18'h0, DATA_A);

        // ---------------- backpressure on write cycles 3 and 4 ----------------
        tick();
        launch(DATA_A);
        w = 0;
        for (int c = 0; c < 8; c++) begin
            rdy       = (c != 2 && c != 3);
            mem_ready = rdy;
            @(negedge clk);
            check($sformatf("bp_we%0d", c),   mem_we,   1'b1);
            check($sformatf("bp_addr%0d", c), mem_addr, 18'(w));
            check($sformatf("bp_din%0d", c),  mem_din,  byte_tab[w]);
            if (rdy) w++;
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);   // FINISH, two cycles later than without backpressure
        check("bp_fin_we",   mem_we, 1'b0);
        check("bp_fin_done", done,   1'b0);
        @(negedge clk);
        check("bp_done", done, 1'b1);
        check_log("bp", 18'h0, DATA_A);

        // ---------------- start held high for 100 ns ----------------
        tick();
        clear_log();
        start   = 1'b1;
        data_in = DATA_A;
        repeat (10) tick();
        check("hold_done",   done,   1'b1);
        check("hold_busy",   busy,   1'b0);
        check("hold_we",     mem_we, 1'b0);
        repeat (3) tick();
        check("hold_norelaunch_busy", busy, 1'b0);
        check_log("hold", 18'h0, DATA_A);
        start = 1'b0;
        tick();
        launch(DATA_B);
        @(negedge clk);
        check("relaunch_done_clr", done,     1'b0);
        check("relaunch_busy",     busy,     1'b1);
        check("relaunch_din",      mem_din,  8'hAA);
        tick();
        wait_done("relaunch", 20);
        check_log("relaunch", 18'h0, DATA_B);

        // ---------------- data_in changes after launch ----------------
        tick();
        launch(DATA_A);
        data_in = 48'hFF_FF_FF_FF_FF_FF;
        wait_done("snap", 20);
        check_log("snap", 18'h0, DATA_A);

        // ---------------- reset after the 2nd accepted write ----------------
        tick();
        launch(DATA_A);
        for (int n = 0; n < 20 && log_addr.size() < 2; n++) tick();
        check("rst_mid_two_writes", log_addr.size(), 2);
        #2;
        rst_n = 1'b0;
        #1;               // well before the next rising edge
        check("rst_async_we",   mem_we, 1'b0);
        check("rst_async_busy", busy,   1'b0);
        check("rst_async_done", done,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("rst_idle_we",    mem_we,          1'b0);
        check("rst_idle_busy",  busy,            1'b0);
        check("rst_idle_done",  done,            1'b0);
        check("rst_no_writes",  log_addr.size(), 2);
        launch(DATA_A);
        wait_done("post_rst", 20);
        check_log("post_rst", 18'h0, DATA_A);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_weight_writer_layer1
